spectrum_frame_loader: RTL
==========================

// Module: spectrum_frame_loader
// PURPOSE
//  Streaming-to-parallel writer feeding the find_maximas reduction tree.
//  Accepts FFT magnitude bins one per beat (valid/ready, last-marked), assembles a SIZE-bin frame,
//  presents it on a parallel bus, then issues a one-cycle load strobe to reduction_stage_1.
//  Holds the frame stable and stalls the stream until the consumer acknowledges.
//  Resynchronises on malformed frames.
// PARAMETERS
//  SIZE    512  bins per frame (power of two, >=4)
//  BIN_W   16   magnitude width per bin
//  IDX_W   $clog2(SIZE)  write-index width (localparam, not overridable)
// PORTS
//  clk          in   1            system clock, all logic on posedge
//  reset_n      in   1            asynchronous active-low reset
//  in_valid     in   1            upstream bin valid
//  in_ready     out  1            loader can accept a bin this cycle
//  in_data      in   BIN_W        bin magnitude
//  in_last      in   1            marks final bin (index SIZE-1) of a frame
//  out_frame    out  BIN_W x SIZE registered frame, bin k at out_frame[k]; drives stage-1 'in'
//  load         out  1            one-cycle strobe, frame valid; drives stage-1 'load'
//  consumer_ack in   1            consumer has captured frame (stage-1 out_active)
//  frame_err    out  1            one-cycle pulse on malformed frame
//  drop_cnt     out  16           saturating count of discarded frames
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - state=FILL, wr_idx=0, out_frame all 0, load=0, frame_err=0, drop_cnt=0.
//   - in_ready=1 one cycle after deassertion.
//  States: FILL, LOAD, WAIT_ACK, RESYNC. All outputs registered except in_ready.
//   - in_ready is decoded from the state register only: 1 in FILL and RESYNC, 0 in LOAD and WAIT_ACK.
//  Accept = in_valid & in_ready.
//  FILL
//   - On accept: out_frame[wr_idx] <= in_data; wr_idx++.
//   - Accept with wr_idx==SIZE-1 and in_last=1 -> LOAD, wr_idx <= 0.
//   - Accept with in_last=1 and wr_idx!=SIZE-1 (short frame) -> stay FILL, wr_idx <= 0,
//     frame_err pulse, drop_cnt++. The partial bins already written are left in out_frame.
//   - Accept with wr_idx==SIZE-1 and in_last=0 (long frame) -> RESYNC, frame_err pulse, drop_cnt++.
//  LOAD
//   - Lasts exactly one cycle; load=1 here only -> WAIT_ACK.
//   - Latency: last bin accepted in cycle N -> load high in cycle N+1.
//  WAIT_ACK
//   - out_frame frozen; stays until consumer_ack=1, then -> FILL with in_ready=1 next cycle.
//   - consumer_ack is sampled only in WAIT_ACK; it is ignored in every other state.
//  RESYNC
//   - Accepts and discards beats; out_frame untouched.
//   - Accept with in_last=1 -> FILL, wr_idx=0. No further error pulses while in RESYNC.
//  drop_cnt saturates at 16'hFFFF, never wraps.
//  Bin 0 is passed raw; DC suppression is the consumer's job.
//  Reset mid-frame or mid-WAIT_ACK discards everything: outputs return to reset values,
//  and load is never emitted for a partial frame.
// STRUCTURE
//  find_maximas_pkg holds:
//   - BIN_W and SIZE defaults shared with reduction_stage_1;
//   - typedef logic [BIN_W-1:0] bin_t;
//   - typedef enum logic [1:0] {FILL, LOAD, WAIT_ACK, RESYNC} loader_state_t.
//  One sub-module, sat_counter #(W=16): async active-low reset, inc input, saturating.
//  Used for drop_cnt and reusable elsewhere in the tree.
//  Frame storage is a flat register array (fanout to stage 1 is fully parallel), not RAM.
// TESTING
//  1. Reset, stream bins k -> data=k+1 for k=0..511 with in_last on k=511:
//     load high exactly 1 cycle after the last accept; out_frame[k]==k+1; in_ready=0 from then.
//  2. From WAIT_ACK, hold consumer_ack=0 for 20 cycles with in_valid=1:
//     in_ready stays 0, out_frame unchanged. Pulse ack: in_ready=1 next cycle, next frame fills from bin 0.
//  3. Short frame, in_last on bin 100:
//     frame_err 1-cycle pulse, drop_cnt=1, no load; a following good frame loads normally.
//  4. Long frame, 600 beats with in_last on beat 599:
//     frame_err once at beat 511, beats 512-599 discarded, drop_cnt=1; next 512-beat frame loads correctly.
//  5. Assert reset_n=0 asynchronously mid-cycle at bin 300:
//     outputs clear immediately; the next full frame loads with no stale data or spurious load.
//  6. Force drop_cnt to 16'hFFFE, inject 3 short frames: drop_cnt ends at 16'hFFFF.
//     Random in_valid gaps (50%) on a good frame still give a correct frame and exactly one load.

Source files
------------

// File: rtl/find_maximas_pkg.sv
// Shared types and defaults for the find_maximas reduction tree and its frame loader.
package find_maximas_pkg;

  localparam int unsigned FM_BIN_W = 16;
  localparam int unsigned FM_SIZE  = 512;

  typedef logic [FM_BIN_W-1:0] bin_t;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2,
    RESYNC   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_CNT = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/spectrum_frame_loader.sv
// Assembles a stream of FFT bins into a parallel frame and hands it to stage 1
// with a one-cycle load strobe, stalling the stream until the consumer acks.
module spectrum_frame_loader
  import find_maximas_pkg::*;
#(
  parameter int unsigned SIZE  = FM_SIZE,
  parameter int unsigned BIN_W = FM_BIN_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIN_W-1:0]            in_data,
  input  logic                        in_last,
  output logic [SIZE-1:0][BIN_W-1:0]  out_frame,
  output logic                        load,
  input  logic                        consumer_ack,
  output logic                        frame_err,
  output logic [15:0]                 drop_cnt
);

  localparam int unsigned     IDX_W    = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  loader_state_t               r_state;
  loader_state_t               w_state_next;
  logic [IDX_W-1:0]            r_wr_idx;
  logic [IDX_W-1:0]            w_wr_idx_next;
  logic [SIZE-1:0][BIN_W-1:0]  r_frame;
  logic                        r_load;
  logic                        r_frame_err;
  logic                        w_ready;
  logic                        w_accept;
  logic                        w_wr_en;
  logic                        w_err;

  // Ready depends on the state register alone, so it never combinationally follows in_valid.
  assign w_ready  = (r_state == FILL) || (r_state == RESYNC);
  assign w_accept = in_valid && w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= FILL;
      r_wr_idx <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wr_idx <= w_wr_idx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_wr_idx_next = r_wr_idx;
    w_wr_en       = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (r_wr_idx == LAST_IDX) begin
            w_wr_idx_next = '0;
            if (in_last) begin
              w_state_next = LOAD;
            end else begin
              w_state_next = RESYNC;
              w_err        = 1'b1;
            end
          end else if (in_last) begin
            w_wr_idx_next = '0;
            w_err         = 1'b1;
          end else begin
            w_wr_idx_next = r_wr_idx + IDX_W'(1);
          end
        end
      end
      LOAD: begin
        w_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (consumer_ack) begin
          w_state_next = FILL;
        end
      end
      RESYNC: begin
        // Swallow beats until the stream marks a frame boundary.
        if (w_accept && in_last) begin
          w_state_next  = FILL;
          w_wr_idx_next = '0;
        end
      end
      default: begin
        w_state_next  = FILL;
        w_wr_idx_next = '0;
      end
    endcase
  end

  // Flat register storage: every bin fans out to stage 1 in parallel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
    end else if (w_wr_en) begin
      r_frame[r_wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_load      <= (w_state_next == LOAD);
      r_frame_err <= w_err;
    end
  end

  sat_counter #(
    .W(16)
  ) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_err),
    .o_count (drop_cnt)
  );

  assign in_ready  = w_ready;
  assign out_frame = r_frame;
  assign load      = r_load;
  assign frame_err = r_frame_err;

endmodule
